// File: rtl/tex_dcr_ctrl_pkg.sv
// tex_types: shared types and constants for the texture DCR controller.
//   tex_dcrs_t       - per-stage texture configuration as seen by the sampler
//   TEX_DCR_*        - DCR register offsets relative to the controller base
//   NUM_TEX_DCRS     - number of mapped DCR offsets (fields + STAGE + COMMIT)
//   drain_state_e    - commit drain FSM encoding
//   is_field_off()   - true for offsets that target a per-stage field
package tex_types;

  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_LOD_MAX     = 3;
  localparam int TEX_MIPOFF_BITS = 20;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;
  localparam int TEX_WRAP_BITS   = 2;

  localparam logic [11:0] TEX_DCR_STAGE   = 12'd0;
  localparam logic [11:0] TEX_DCR_ADDR    = 12'd1;
  localparam logic [11:0] TEX_DCR_LOGDIM  = 12'd2;
  localparam logic [11:0] TEX_DCR_FORMAT  = 12'd3;
  localparam logic [11:0] TEX_DCR_FILTER  = 12'd4;
  localparam logic [11:0] TEX_DCR_WRAP    = 12'd5;
  localparam logic [11:0] TEX_DCR_MIPOFF0 = 12'd6;
  localparam logic [11:0] TEX_DCR_COMMIT  = 12'(7 + TEX_LOD_MAX);

  localparam int NUM_TEX_DCRS = 8 + TEX_LOD_MAX;

  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                    baddr;
    logic [1:0][TEX_LOD_BITS-1:0]                logdim;  // [0]=u, [1]=v
    logic [TEX_FORMAT_BITS-1:0]                  format;
    logic [TEX_FILTER_BITS-1:0]                  filter;
    logic [1:0][TEX_WRAP_BITS-1:0]               wrap;    // [0]=u, [1]=v
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]   mipoff;
  } tex_dcrs_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } drain_state_e;

  // Field offsets sit between STAGE and COMMIT.
  function automatic logic is_field_off(logic [11:0] off);
    return (off >= TEX_DCR_ADDR) && (off < 12'(NUM_TEX_DCRS - 1));
  endfunction

endpackage

// File: rtl/tex_dcr_ctrl_if.sv
// tex_dcr_ctrl_if: DCR write port, sampler request/response port and status.
//   master - DCR bus + sampler side (drives valids, data, tex_done, rsp_ready)
//   slave  - tex_dcr_ctrl
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where valid and ready are both 1; the initiator holds
// valid and its payload stable until that edge, and ready never depends on
// valid in the same cycle.
interface tex_dcr_ctrl_if #(
  parameter int NUM_STAGES   = 4,
  parameter int MAX_INFLIGHT = 16
);
  import tex_types::*;

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic          dcr_wr_valid;
  logic          dcr_wr_ready;
  logic [11:0]   dcr_wr_addr;
  logic [31:0]   dcr_wr_data;

  logic          tex_req_valid;
  logic          tex_req_ready;
  logic [SW-1:0] tex_req_stage;

  logic          tex_rsp_valid;
  logic          tex_rsp_ready;
  tex_dcrs_t     tex_rsp_dcrs;

  logic          tex_done;
  logic          commit_pending;
  logic [IW-1:0] inflight;
  drain_state_e  dbg_state;

  modport master (
    output dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
    output tex_req_valid, tex_req_stage, tex_rsp_ready, tex_done,
    input  dcr_wr_ready, tex_req_ready, tex_rsp_valid, tex_rsp_dcrs,
    input  commit_pending, inflight, dbg_state
  );

  modport slave (
    input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
    input  tex_req_valid, tex_req_stage, tex_rsp_ready, tex_done,
    output dcr_wr_ready, tex_req_ready, tex_rsp_valid, tex_rsp_dcrs,
    output commit_pending, inflight, dbg_state
  );

endinterface

// File: rtl/tex_dcr_bank.sv
// tex_dcr_bank: shadow + active configuration for one texture stage.
//   clk, reset  - clock, async active-high reset
//   i_wr_en     - a field write targets this stage this cycle
//   i_wr_off    - DCR offset of the write (only field offsets arrive here)
//   i_wr_data   - DCR write data
//   i_commit    - copy shadow into active at this edge
//   o_active    - active configuration returned to the sampler
module tex_dcr_bank
  import tex_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_en,
  input  logic [11:0] i_wr_off,
  input  logic [31:0] i_wr_data,
  input  logic        i_commit,
  output tex_dcrs_t   o_active
);

  tex_dcrs_t r_shadow;
  tex_dcrs_t r_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (i_wr_en) begin
      case (i_wr_off)
        TEX_DCR_ADDR:   r_shadow.baddr <= i_wr_data[TEX_ADDR_BITS-1:0];
        TEX_DCR_LOGDIM: begin
          r_shadow.logdim[0] <= i_wr_data[TEX_LOD_BITS-1:0];
          r_shadow.logdim[1] <= i_wr_data[4 +: TEX_LOD_BITS];
        end
        TEX_DCR_FORMAT: r_shadow.format <= i_wr_data[TEX_FORMAT_BITS-1:0];
        TEX_DCR_FILTER: r_shadow.filter <= i_wr_data[TEX_FILTER_BITS-1:0];
        TEX_DCR_WRAP: begin
          r_shadow.wrap[0] <= i_wr_data[1:0];
          r_shadow.wrap[1] <= i_wr_data[3:2];
        end
        default: begin
          for (int k = 0; k <= TEX_LOD_MAX; k++) begin
            if (i_wr_off == TEX_DCR_MIPOFF0 + 12'(k))
              r_shadow.mipoff[k] <= i_wr_data[TEX_MIPOFF_BITS-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_active <= '0;
    else if (i_commit) r_active <= r_shadow;
  end

  assign o_active = r_active;

endmodule

// File: rtl/tex_dcr_ctrl.sv
// tex_dcr_ctrl: per-stage texture configuration owner.
//   clk, reset - clock, async active-high reset
//   bus        - tex_dcr_ctrl_if.slave: DCR writes, sampler requests and
//                1-deep registered responses, tex_done retire pulses,
//                commit_pending / inflight status, dbg_state (drain FSM)
// DCR field writes land in the shadow bank of the current STAGE. COMMIT
// waits until no request is in flight and the response register is empty,
// then copies that stage's shadow into its active bank.
module tex_dcr_ctrl
  import tex_types::*;
#(
  parameter int          NUM_STAGES   = 4,
  parameter logic [11:0] DCR_BASE     = 12'h100,
  parameter int          MAX_INFLIGHT = 16
)(
  input  logic          clk,
  input  logic          reset,
  tex_dcr_ctrl_if.slave bus
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  drain_state_e  r_state, w_state_nxt;
  logic [SW-1:0] r_stage, r_commit_stage;
  logic [IW-1:0] r_inflight;
  logic          r_rsp_valid;
  tex_dcrs_t     r_rsp_dcrs;

  logic [11:0]   w_off;
  logic [31:0]   w_stage_mod;
  logic          w_wr_ready, w_wr_fire, w_field_wr, w_commit_wr;
  logic          w_req_ready, w_req_fire, w_done_eff;
  logic          w_commit_pending, w_commit_go;
  tex_dcrs_t     w_active [NUM_STAGES];

  assign w_off       = bus.dcr_wr_addr - DCR_BASE;
  assign w_stage_mod = bus.dcr_wr_data % NUM_STAGES;
  assign w_wr_ready  = !w_commit_pending;
  assign w_wr_fire   = bus.dcr_wr_valid && w_wr_ready;
  assign w_field_wr  = w_wr_fire && is_field_off(w_off);
  assign w_commit_wr = w_wr_fire && (w_off == TEX_DCR_COMMIT);

  // A new request may load the response register only if it is free or
  // being drained in the same cycle.
  assign w_req_ready = !w_commit_pending && (r_inflight < IW'(MAX_INFLIGHT)) &&
                       (!r_rsp_valid || bus.tex_rsp_ready);
  assign w_req_fire  = bus.tex_req_valid && w_req_ready;
  // Retire pulses with nothing in flight are dropped.
  assign w_done_eff  = bus.tex_done && (r_inflight != '0);

  // Drain FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Drain FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_commit_wr) w_state_nxt = ST_PENDING;
      ST_PENDING: if (r_inflight == '0 && !r_rsp_valid) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Drain FSM: outputs
  always_comb begin
    w_commit_pending = (r_state == ST_PENDING);
    w_commit_go      = (r_state == ST_PENDING) && (r_inflight == '0) && !r_rsp_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage        <= '0;
      r_commit_stage <= '0;
    end else begin
      if (w_wr_fire && w_off == TEX_DCR_STAGE) r_stage <= SW'(w_stage_mod);
      if (w_commit_wr)                          r_commit_stage <= r_stage;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
    end else if (w_req_fire && !w_done_eff) begin
      r_inflight <= r_inflight + IW'(1);
    end else if (!w_req_fire && w_done_eff) begin
      r_inflight <= r_inflight - IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_dcrs  <= '0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_dcrs  <= w_active[bus.tex_req_stage];
    end else if (bus.tex_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_bank
    tex_dcr_bank u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_field_wr && (r_stage == SW'(g))),
      .i_wr_off  (w_off),
      .i_wr_data (bus.dcr_wr_data),
      .i_commit  (w_commit_go && (r_commit_stage == SW'(g))),
      .o_active  (w_active[g])
    );
  end

  assign bus.dcr_wr_ready   = w_wr_ready;
  assign bus.tex_req_ready  = w_req_ready;
  assign bus.tex_rsp_valid  = r_rsp_valid;
  assign bus.tex_rsp_dcrs   = r_rsp_dcrs;
  assign bus.commit_pending = w_commit_pending;
  assign bus.inflight       = r_inflight;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_tex_dcr_ctrl.sv
// tb_tex_dcr_ctrl: bench for tex_dcr_ctrl. The reference model keeps the
// architectural shadow/active configuration per stage; a COMMIT is applied to
// the model when it is written, since no request can be admitted between the
// COMMIT write and the actual copy.
module tb_tex_dcr_ctrl;
  import tex_types::*;

  localparam int          NUM_STAGES   = 4;
  localparam int          MAX_INFLIGHT = 16;
  localparam logic [11:0] DCR_BASE     = 12'h100;
  localparam int          DW           = $bits(tex_dcrs_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tex_dcr_ctrl_if #(.NUM_STAGES(NUM_STAGES), .MAX_INFLIGHT(MAX_INFLIGHT)) bus ();

  tex_dcr_ctrl #(
    .NUM_STAGES  (NUM_STAGES),
    .DCR_BASE    (DCR_BASE),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- model + scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  tex_dcrs_t shadow_m [NUM_STAGES];
  tex_dcrs_t active_m [NUM_STAGES];
  int  stage_m;
  int  inflight_m;
  bit  rescue;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tex_dcrs_t apply_field(tex_dcrs_t cur, int off, logic [31:0] d);
    tex_dcrs_t r = cur;
    case (off)
      1: r.baddr = d;
      2: begin r.logdim[0] = d[3:0]; r.logdim[1] = d[7:4]; end
      3: r.format = d[2:0];
      4: r.filter = d[1:0];
      5: begin r.wrap[0] = d[1:0]; r.wrap[1] = d[3:2]; end
      6, 7, 8, 9: r.mipoff[off-6] = d[19:0];
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NUM_STAGES; s++) begin
      shadow_m[s] = '0;
      active_m[s] = '0;
    end
    stage_m    = 0;
    inflight_m = 0;
    exp_q.delete();
  endtask

  task automatic model_write(input logic [11:0] addr, input logic [31:0] data);
    logic [11:0] off;
    off = addr - DCR_BASE;
    if (off == 12'd0)       stage_m = int'(data % NUM_STAGES);
    else if (off == 12'd10) active_m[stage_m] = shadow_m[stage_m];
    else if (off >= 12'd1 && off <= 12'd9)
      shadow_m[stage_m] = apply_field(shadow_m[stage_m], int'(off), data);
  endtask

  // Monitor: every response handshake is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.tex_rsp_valid && bus.tex_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got %h expected no response", bus.tex_rsp_dcrs);
      end else begin
        check("rsp_dcrs", bus.tex_rsp_dcrs, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dcr_write(input logic [11:0] addr, input logic [31:0] data);
    int n = 0;
    bus.dcr_wr_valid = 1'b1;
    bus.dcr_wr_addr  = addr;
    bus.dcr_wr_data  = data;
    @(negedge clk);
    while (!bus.dcr_wr_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("dcr_wr_accept", bus.dcr_wr_ready, 1'b1);
    if (bus.dcr_wr_ready) model_write(addr, data);
    tick();
    bus.dcr_wr_valid = 1'b0;
  endtask

  task automatic tex_req(input int stage);
    int n = 0;
    bus.tex_req_valid = 1'b1;
    bus.tex_req_stage = 2'(stage);
    @(negedge clk);
    while (!bus.tex_req_ready && n < 50) begin
      n++;
      tick();
      if (rescue && n > 3) bus.tex_rsp_ready = 1'b1;
      @(negedge clk);
    end
    check("req_accept", bus.tex_req_ready, 1'b1);
    if (bus.tex_req_ready) begin
      exp_q.push_back(active_m[stage]);
      inflight_m++;
    end
    tick();
    bus.tex_req_valid = 1'b0;
  endtask

  task automatic done_pulse();
    bus.tex_done = 1'b1;
    if (inflight_m > 0) inflight_m--;
    tick();
    bus.tex_done = 1'b0;
  endtask

  task automatic drain();
    bus.tex_rsp_ready = 1'b1;
    while (inflight_m > 0) done_pulse();
  endtask

  task automatic wait_commit_clear();
    int n = 0;
    while (bus.commit_pending && n < 100) begin
      tick();
      n++;
    end
    check("commit_clear", bus.commit_pending, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"},  bus.dcr_wr_ready,   1'b1);
    check({tag, "_req_ready"}, bus.tex_req_ready,  1'b1);
    check({tag, "_rsp_valid"}, bus.tex_rsp_valid,  1'b0);
    check({tag, "_pending"},   bus.commit_pending, 1'b0);
    check({tag, "_inflight"},  bus.inflight,       0);
    check({tag, "_rsp_dcrs"},  bus.tex_rsp_dcrs,   0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    tex_dcrs_t held;
    int stalls;
    int op;

    bus.dcr_wr_valid  = 1'b0;
    bus.dcr_wr_addr   = '0;
    bus.dcr_wr_data   = '0;
    bus.tex_req_valid = 1'b0;
    bus.tex_req_stage = '0;
    bus.tex_rsp_ready = 1'b1;
    bus.tex_done      = 1'b0;
    rescue            = 1'b0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // 1: basic commit with nothing in flight
    dcr_write(DCR_BASE + TEX_DCR_STAGE,  32'd1);
    dcr_write(DCR_BASE + TEX_DCR_ADDR,   32'h8000_0000);
    dcr_write(DCR_BASE + TEX_DCR_FORMAT, 32'd2);
    dcr_write(DCR_BASE + TEX_DCR_COMMIT, 32'hFFFF_FFFF);
    check("t1_pending_set", bus.commit_pending, 1'b1);
    check("t1_wr_stall",    bus.dcr_wr_ready,   1'b0);
    tick();
    check("t1_pending_lat1", bus.commit_pending, 1'b0);
    tex_req(1);
    check("t1_rsp_valid", bus.tex_rsp_valid, 1'b1);
    check("t1_baddr",     bus.tex_rsp_dcrs.baddr, 32'h8000_0000);
    check("t1_format",    bus.tex_rsp_dcrs.format, 3'd2);
    tex_req(0);
    check("t1_stage0_zero", bus.tex_rsp_dcrs, 0);
    drain();
    check("t1_inflight0", bus.inflight, 0);

    // 2: commit waits for in-flight drain
    dcr_write(DCR_BASE + TEX_DCR_FILTER, 32'd3);
    dcr_write(DCR_BASE + TEX_DCR_WRAP,   32'h6);
    dcr_write(DCR_BASE + TEX_DCR_LOGDIM, 32'hA7);
    repeat (3) tex_req(1);
    check("t2_inflight3", bus.inflight, 3);
    dcr_write(DCR_BASE + TEX_DCR_COMMIT, 32'd0);
    check("t2_pending",   bus.commit_pending, 1'b1);
    check("t2_wr_stall",  bus.dcr_wr_ready,   1'b0);
    check("t2_req_stall", bus.tex_req_ready,  1'b0);
    done_pulse();
    done_pulse();
    check("t2_still_pending", bus.commit_pending, 1'b1);
    done_pulse();
    check("t2_go_cycle_pending", bus.commit_pending, 1'b1);
    check("t2_go_cycle_inflight", bus.inflight, 0);
    tick();
    check("t2_pending_clear", bus.commit_pending, 1'b0);
    tex_req(1);
    check("t2_new_filter", bus.tex_rsp_dcrs.filter, 2'd3);
    drain();

    // 3: inflight limit and simultaneous fire/done
    for (int i = 0; i < MAX_INFLIGHT; i++) tex_req($urandom_range(0, NUM_STAGES - 1));
    check("t3_inflight_max", bus.inflight, MAX_INFLIGHT);
    check("t3_req_blocked",  bus.tex_req_ready, 1'b0);
    done_pulse();
    check("t3_inflight_15", bus.inflight, MAX_INFLIGHT - 1);
    check("t3_req_open",    bus.tex_req_ready, 1'b1);
    bus.tex_req_valid = 1'b1;
    bus.tex_req_stage = 2'($urandom_range(0, NUM_STAGES - 1));
    bus.tex_done      = 1'b1;
    @(negedge clk);
    check("t3_simul_ready", bus.tex_req_ready, 1'b1);
    if (bus.tex_req_ready) exp_q.push_back(active_m[bus.tex_req_stage]);
    tick();
    bus.tex_req_valid = 1'b0;
    bus.tex_done      = 1'b0;
    check("t3_simul_const", bus.inflight, MAX_INFLIGHT - 1);
    drain();
    check("t3_drained", bus.inflight, 0);
    done_pulse();
    check("t3_done_at_zero", bus.inflight, 0);

    // 4: response back-pressure, commit held by a full response register
    bus.tex_rsp_ready = 1'b0;
    tex_req(2);
    held = active_m[2];
    done_pulse();
    dcr_write(DCR_BASE + TEX_DCR_STAGE, 32'd2);
    dcr_write(DCR_BASE + TEX_DCR_ADDR,  32'h0000_1234);
    dcr_write(DCR_BASE + TEX_DCR_COMMIT, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_req_blocked", bus.tex_req_ready,  1'b0);
      check("t4_rsp_held",    bus.tex_rsp_valid,  1'b1);
      check("t4_rsp_stable",  bus.tex_rsp_dcrs,   held);
      check("t4_pending",     bus.commit_pending, 1'b1);
    end
    bus.tex_rsp_ready = 1'b1;
    wait_commit_clear();
    stalls = 0;
    for (int i = 0; i < 8;) begin
      bus.tex_req_valid = 1'b1;
      bus.tex_req_stage = 2'($urandom_range(0, NUM_STAGES - 1));
      @(negedge clk);
      if (bus.tex_req_ready) begin
        exp_q.push_back(active_m[bus.tex_req_stage]);
        inflight_m++;
        i++;
      end else begin
        stalls++;
      end
      tick();
      if (stalls > 20) break;
    end
    bus.tex_req_valid = 1'b0;
    check("t4_burst_stalls", stalls, 0);
    drain();

    // 5: STAGE wrap, unmapped addresses, stray tex_done
    dcr_write(DCR_BASE + TEX_DCR_STAGE,  32'd5);
    dcr_write(DCR_BASE + TEX_DCR_FORMAT, 32'd5);
    dcr_write(DCR_BASE + TEX_DCR_MIPOFF0 + 12'd2, 32'hFFFA_BCDE);
    dcr_write(DCR_BASE + TEX_DCR_COMMIT, 32'd0);
    wait_commit_clear();
    tex_req(1);
    check("t5_wrap_format", bus.tex_rsp_dcrs.format, 3'd5);
    check("t5_wrap_mip2",   bus.tex_rsp_dcrs.mipoff[2], 20'hABCDE);
    dcr_write(12'h0FF, 32'hDEAD_BEEF);
    dcr_write(DCR_BASE + TEX_DCR_COMMIT + 12'd1, 32'h1234_5678);
    dcr_write(12'h3FF, 32'h0000_0001);
    check("t5_unmapped_pending", bus.commit_pending, 1'b0);
    for (int s = 0; s < NUM_STAGES; s++) tex_req(s);
    drain();
    done_pulse();
    check("t5_done_at_zero", bus.inflight, 0);

    // random phase
    rescue = 1'b1;
    repeat (300) begin
      op = $urandom_range(0, 8);
      if (op <= 2) begin
        dcr_write(DCR_BASE + 12'($urandom_range(0, 9)), $urandom);
      end else if (op == 3) begin
        dcr_write(DCR_BASE + TEX_DCR_COMMIT, $urandom);
        drain();
        wait_commit_clear();
      end else if (op <= 6) begin
        if (inflight_m < MAX_INFLIGHT) tex_req($urandom_range(0, NUM_STAGES - 1));
        else done_pulse();
      end else if (op == 7) begin
        done_pulse();
      end else begin
        bus.tex_rsp_ready = 1'($urandom_range(0, 1));
        tick();
      end
      check("rand_inflight", bus.inflight, inflight_m);
    end
    rescue = 1'b0;
    drain();
    tick();

    // 6: reset during a pending commit drops it
    tex_req(3);
    dcr_write(DCR_BASE + TEX_DCR_STAGE, 32'd3);
    dcr_write(DCR_BASE + TEX_DCR_ADDR,  32'hDEAD_0000);
    dcr_write(DCR_BASE + TEX_DCR_COMMIT, 32'd0);
    check("t6_pending", bus.commit_pending, 1'b1);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) tick();
    check("t6_no_pending", bus.commit_pending, 1'b0);
    tex_req(3);
    check("t6_stage3_zero", bus.tex_rsp_dcrs, 0);
    drain();
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tex_dcr_ctrl.md
Name: tex_dcr_ctrl

Overview:
- Owns the per-stage texture configuration (tex_dcrs_t) for the texture unit.
- DCR writes land in a per-stage shadow copy. A COMMIT write copies the shadow into the active copy, but only after all in-flight texture requests have drained.
- Texture requests are admitted per stage and answered with the active tex_dcrs_t for that stage through a 1-deep registered response.
- Sits between the DCR bus and the texture sampler front-end.

Parameters:
- NUM_STAGES, 4: number of texture stages (bindings).
- DCR_BASE, 12'h100: DCR address of register offset 0.
- MAX_INFLIGHT, 16: maximum number of accepted but not yet retired texture requests.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dcr_wr_valid  in  1  DCR write strobe
- dcr_wr_ready  out  1  DCR write accepted
- dcr_wr_addr  in  12  DCR address
- dcr_wr_data  in  32  DCR data
- tex_req_valid  in  1  sampler lookup request
- tex_req_ready  out  1  lookup accepted
- tex_req_stage  in  clog2(NUM_STAGES)  stage index
- tex_rsp_valid  out  1  response register holds data
- tex_rsp_ready  in  1  response consumed
- tex_rsp_dcrs  out  $bits(tex_dcrs_t)  active config of the requested stage
- tex_done  in  1  one request retired in the sampler (pulse)
- commit_pending  out  1  a commit is waiting for drain
- inflight  out  clog2(MAX_INFLIGHT+1)  current in-flight count

Behaviour:
- Reset: all shadow and active banks, STAGE, the response register, inflight and commit_pending clear to 0. dcr_wr_ready=1, tex_req_ready=1, tex_rsp_valid=0.
- Register map, offset = dcr_wr_addr - DCR_BASE:
  - 0 STAGE: [clog2(NUM_STAGES)-1:0].
  - 1 ADDR: baddr[TEX_ADDR_BITS-1:0].
  - 2 LOGDIM: u=[3:0], v=[7:4], each truncated to TEX_LOD_BITS.
  - 3 FORMAT.
  - 4 FILTER.
  - 5 WRAP: u=[1:0], v=[3:2].
  - 6..6+TEX_LOD_MAX: mipoff[k] = data[TEX_MIPOFF_BITS-1:0].
  - 7+TEX_LOD_MAX: COMMIT (data ignored).
  - Other addresses are accepted and ignored.
- Field writes (offsets 1 through 6+TEX_LOD_MAX) update shadow[STAGE] in the cycle after the write fires. A STAGE value >= NUM_STAGES wraps modulo NUM_STAGES.
- dcr_wr_ready = !commit_pending. Writes are stalled while a commit waits.
- COMMIT fire: latch commit_stage=STAGE and set commit_pending. Commit completes in the first cycle in which inflight==0 and the response register is empty. In that cycle:
  - active[commit_stage] <= shadow[commit_stage];
  - commit_pending clears.
  - If inflight==0 when COMMIT fires, the copy occurs on the next cycle, so commit latency is 1 cycle.
- Request admission: tex_req_ready = !commit_pending && inflight<MAX_INFLIGHT && (!tex_rsp_valid || tex_rsp_ready).
- On req fire, the response register loads active[tex_req_stage] and tex_rsp_valid=1 on the next cycle. Request-to-response latency is 1 cycle, with back-to-back throughput of 1 per cycle when tex_rsp_ready=1.
- A response persists, unchanged, until tex_rsp_ready.
- inflight:
  - +1 on req fire, -1 on tex_done.
  - Both in the same cycle: no change.
  - tex_done at 0: ignored, counter stays 0.
  - Never exceeds MAX_INFLIGHT, because admission blocks at the limit.
- Only the committed stage changes. Responses already issued keep the old config.
- A reset asserted mid-commit drops the commit; active banks return to 0.

Decomposition:
- Package tex_types:
  - tex_dcrs_t;
  - DCR offset localparams: TEX_DCR_STAGE, ADDR, LOGDIM, FORMAT, FILTER, WRAP, MIPOFF0, COMMIT;
  - a NUM_TEX_DCRS constant.
- One sub-module, tex_dcr_bank: shadow/active storage for one stage, with field-write decode and a commit input. It is instantiated NUM_STAGES times. The top level holds the STAGE register, the drain FSM (IDLE / PENDING), the inflight counter and the response register.

Test Plan:
1. Write STAGE=1, ADDR=0x8000_0000, FORMAT=2, then COMMIT with inflight=0. Then request stage 1 -> 1 cycle later tex_rsp_dcrs.baddr=0x8000_0000, format=2. A request to stage 0 -> all zeros.
2. Accept 3 requests with no tex_done, then write COMMIT -> commit_pending=1, dcr_wr_ready=0 and tex_req_ready=0. After 3 tex_done pulses and the response is drained -> commit applies, pending clears on that cycle, and a new request returns the new config.
3. Issue 16 requests with no tex_done -> tex_req_ready=0 at inflight=16. One tex_done -> tex_req_ready=1. A simultaneous fire and done -> inflight stays constant.
4. Hold tex_rsp_ready=0 with rsp valid -> tex_req_ready=0 and rsp data stable. Release -> a back-to-back stream runs at 1 per cycle.
5. Write STAGE=5 with NUM_STAGES=4 -> fields land in stage 1. Write an unmapped address -> accepted, no state change. tex_done at inflight=0 -> stays 0.
6. Assert reset while commit_pending=1 -> all outputs return to reset values, and no commit is applied after reset.
